// File: rtl/mdio_master_if.sv
// Request/response channel between a management client and the MDIO master.
interface mdio_master_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_clause45;
    logic [1:0]  req_op;
    logic [4:0]  req_phy_address;
    logic [4:0]  req_reg_address;
    logic [15:0] req_data;
    logic        rsp_valid;
    logic [15:0] rsp_data;
    logic        busy;

    modport master (
        output req_valid, req_clause45, req_op, req_phy_address, req_reg_address, req_data,
        input  req_ready, rsp_valid, rsp_data, busy
    );

    modport slave (
        input  req_valid, req_clause45, req_op, req_phy_address, req_reg_address, req_data,
        output req_ready, rsp_valid, rsp_data, busy
    );
endinterface

// File: rtl/mdio_master.sv
// MDIO station-management master: divided MDC, Clause 22/45 frames, split in/out/oe pad signals.
module mdio_master #(
    parameter int unsigned CLOCK_DIVIDE  = 10,
    parameter int unsigned PREAMBLE_BITS = 32,
    parameter bit          SUPPORT_C45   = 1'b1
) (
    input  logic         clock,
    input  logic         reset,
    output logic         mdc,
    input  logic         mdio_in,
    output logic         mdio_out,
    output logic         mdio_oe,
    mdio_master_if.slave bus
);
    localparam int unsigned FRAME_BITS = PREAMBLE_BITS + 32;
    localparam int unsigned CNT_W      = 7;
    localparam int unsigned DIV_W      = (CLOCK_DIVIDE > 1) ? $clog2(CLOCK_DIVIDE) : 1;

    typedef enum logic [3:0] {
        IDLE, PREAMBLE, START, OPCODE, PHY, REG, TURNAROUND, DATA, DONE
    } state_t;

    state_t             state, state_d;
    logic [CNT_W-1:0]   bit_cnt, bit_cnt_d;
    logic [DIV_W-1:0]   div_cnt, div_cnt_d;
    logic               phase_hi, phase_hi_d;
    logic               mdc_d, mdio_out_d, mdio_oe_d;
    logic [31:0]        frame_shift, frame_shift_d;
    logic [15:0]        read_shift, read_shift_d;
    logic               is_read, is_read_d;
    logic               rsp_valid, rsp_valid_d;
    logic [15:0]        rsp_data, rsp_data_d;
    logic               busy, busy_d;
    logic               clause45_c;
    logic               div_end_c;
    state_t             field_c;

    // Frame field that owns bit index b.
    function automatic state_t field_of(input logic [CNT_W-1:0] b);
        int i;
        i = int'(b);
        if (i < int'(PREAMBLE_BITS))           return PREAMBLE;
        else if (i < int'(PREAMBLE_BITS) + 2)  return START;
        else if (i < int'(PREAMBLE_BITS) + 4)  return OPCODE;
        else if (i < int'(PREAMBLE_BITS) + 9)  return PHY;
        else if (i < int'(PREAMBLE_BITS) + 14) return REG;
        else if (i < int'(PREAMBLE_BITS) + 16) return TURNAROUND;
        else                                   return DATA;
    endfunction

    assign clause45_c    = SUPPORT_C45 && bus.req_clause45;
    assign div_end_c     = (div_cnt == DIV_W'(CLOCK_DIVIDE - 1));
    assign field_c       = field_of(bit_cnt);
    assign bus.req_ready = (state == IDLE) && !reset;
    assign bus.rsp_valid = rsp_valid;
    assign bus.rsp_data  = rsp_data;
    assign bus.busy      = busy;

    // Next-state and next-output logic; bit_cnt is the index of the next bit to drive.
    always_comb begin
        state_d       = state;
        bit_cnt_d     = bit_cnt;
        div_cnt_d     = div_cnt;
        phase_hi_d    = phase_hi;
        mdc_d         = mdc;
        mdio_out_d    = mdio_out;
        mdio_oe_d     = mdio_oe;
        frame_shift_d = frame_shift;
        read_shift_d  = read_shift;
        is_read_d     = is_read;
        rsp_valid_d   = 1'b0;
        rsp_data_d    = rsp_data;

        unique case (state)
            IDLE: begin
                mdc_d      = 1'b0;
                mdio_out_d = 1'b1;
                mdio_oe_d  = 1'b0;
                if (bus.req_valid) begin
                    is_read_d     = clause45_c ? bus.req_op[1] : (bus.req_op == 2'b10);
                    frame_shift_d = {clause45_c ? 2'b00 : 2'b01, bus.req_op, bus.req_phy_address,
                                     bus.req_reg_address, 2'b10, bus.req_data};
                    bit_cnt_d     = '0;
                    // Pretend to sit at the end of a high phase so bit 0 starts on the next clock.
                    div_cnt_d     = DIV_W'(CLOCK_DIVIDE - 1);
                    phase_hi_d    = 1'b1;
                    state_d       = (PREAMBLE_BITS != 0) ? PREAMBLE : START;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                if (!div_end_c) begin
                    div_cnt_d = div_cnt + DIV_W'(1);
                end else begin
                    div_cnt_d = '0;
                    if (!phase_hi) begin
                        phase_hi_d = 1'b1;
                        mdc_d      = 1'b1;
                        if (state == DATA) read_shift_d = {read_shift[14:0], mdio_in};
                    end else begin
                        phase_hi_d = 1'b0;
                        mdc_d      = 1'b0;
                        if (bit_cnt == CNT_W'(FRAME_BITS)) begin
                            state_d     = DONE;
                            mdio_out_d  = 1'b1;
                            mdio_oe_d   = 1'b0;
                            rsp_valid_d = 1'b1;
                            if (is_read) rsp_data_d = read_shift;
                        end else begin
                            state_d   = field_c;
                            bit_cnt_d = bit_cnt + CNT_W'(1);
                            if (field_c == PREAMBLE) begin
                                mdio_out_d = 1'b1;
                            end else begin
                                mdio_out_d    = frame_shift[31];
                                frame_shift_d = {frame_shift[30:0], 1'b0};
                            end
                            mdio_oe_d = !(is_read && (field_c == TURNAROUND || field_c == DATA));
                        end
                    end
                end
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // State and output registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            bit_cnt     <= '0;
            div_cnt     <= '0;
            phase_hi    <= 1'b0;
            mdc         <= 1'b0;
            mdio_out    <= 1'b1;
            mdio_oe     <= 1'b0;
            frame_shift <= '0;
            read_shift  <= '0;
            is_read     <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_data    <= '0;
            busy        <= 1'b0;
        end else begin
            state       <= state_d;
            bit_cnt     <= bit_cnt_d;
            div_cnt     <= div_cnt_d;
            phase_hi    <= phase_hi_d;
            mdc         <= mdc_d;
            mdio_out    <= mdio_out_d;
            mdio_oe     <= mdio_oe_d;
            frame_shift <= frame_shift_d;
            read_shift  <= read_shift_d;
            is_read     <= is_read_d;
            rsp_valid   <= rsp_valid_d;
            rsp_data    <= rsp_data_d;
            busy        <= busy_d;
        end
    end
endmodule

// File: tb/tb_mdio_master.sv
// Self-checking bench for mdio_master: two parameterisations, a bit-level PHY model and a frame reference model.
`timescale 1ns/1ps
module tb_mdio_master;
    localparam int D_A = 2;
    localparam int P_A = 32;
    localparam int D_B = 1;
    localparam int P_B = 0;

    typedef struct {
        logic        c45;
        logic [1:0]  op;
        logic [4:0]  phy;
        logic [4:0]  ra;
        logic [15:0] data;
        logic [15:0] pv;
    } req_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_a, rst_b;
    logic       mdc_a, mdc_b, mo_a, mo_b, oe_a, oe_b;
    logic [1:0] mi;

    mdio_master_if bus_a();
    mdio_master_if bus_b();

    mdio_master #(.CLOCK_DIVIDE(D_A), .PREAMBLE_BITS(P_A), .SUPPORT_C45(1'b1)) dut_a (
        .clock(clk), .reset(rst_a), .mdc(mdc_a), .mdio_in(mi[0]),
        .mdio_out(mo_a), .mdio_oe(oe_a), .bus(bus_a)
    );
    mdio_master #(.CLOCK_DIVIDE(D_B), .PREAMBLE_BITS(P_B), .SUPPORT_C45(1'b0)) dut_b (
        .clock(clk), .reset(rst_b), .mdc(mdc_b), .mdio_in(mi[1]),
        .mdio_out(mo_b), .mdio_oe(oe_b), .bus(bus_b)
    );

    wire [1:0]  mdc_v  = {mdc_b, mdc_a};
    wire [1:0]  mo_v   = {mo_b, mo_a};
    wire [1:0]  oe_v   = {oe_b, oe_a};
    wire [1:0]  rdy_v  = {bus_b.req_ready, bus_a.req_ready};
    wire [1:0]  rv_v   = {bus_b.rsp_valid, bus_a.rsp_valid};
    wire [1:0]  busy_v = {bus_b.busy, bus_a.busy};
    wire [15:0] rsp_v [2];
    assign rsp_v[0] = bus_a.rsp_data;
    assign rsp_v[1] = bus_b.rsp_data;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [63:0] cap_bits [2];
    logic [63:0] cap_oe   [2];
    int          rc       [2];
    logic [15:0] phy_val  [2];
    logic [15:0] last_rsp [2];
    logic        prev_mdc [2];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int pre_of(input int s);
        return (s == 0) ? P_A : P_B;
    endfunction

    // Capture the pad at every MDC rise and play the PHY's read reply one bit ahead.
    always @(posedge clk) begin
        #1;
        for (int s = 0; s < 2; s++) begin
            if (mdc_v[s] && !prev_mdc[s]) begin
                int p, n, nb;
                p = pre_of(s);
                n = p + 32;
                if (rc[s] < n) begin
                    cap_bits[s][n-1-rc[s]] = mo_v[s];
                    cap_oe[s][n-1-rc[s]]   = oe_v[s];
                end
                nb = rc[s] + 1;
                if (nb == p + 15)                    mi[s] = 1'b0;
                else if (nb >= p + 16 && nb < p + 32) mi[s] = phy_val[s][15-(nb-p-16)];
                else                                 mi[s] = 1'b1;
                rc[s]++;
            end
            prev_mdc[s] = mdc_v[s];
        end
    end

    task automatic drive_req(input int s, input req_t r, input logic v);
        if (s == 0) begin
            bus_a.req_valid = v; bus_a.req_clause45 = r.c45; bus_a.req_op = r.op;
            bus_a.req_phy_address = r.phy; bus_a.req_reg_address = r.ra; bus_a.req_data = r.data;
        end else begin
            bus_b.req_valid = v; bus_b.req_clause45 = r.c45; bus_b.req_op = r.op;
            bus_b.req_phy_address = r.phy; bus_b.req_reg_address = r.ra; bus_b.req_data = r.data;
        end
    endtask

    function automatic req_t rand_req();
        req_t r;
        r.c45  = 1'($urandom_range(0, 1));
        r.op   = 2'($urandom_range(0, 3));
        r.phy  = 5'($urandom);
        r.ra   = 5'($urandom);
        r.data = 16'($urandom);
        r.pv   = 16'($urandom);
        return r;
    endfunction

    // One request through to its response, checked against the frame the rules imply.
    task automatic do_frame(input int s, input req_t r, input bit chained_in,
                            input bit chain_out, input req_t nxt);
        int          d, p, n, waited, cyc, limit, pos;
        logic        c45e, rd, o;
        logic [31:0] f32;
        logic [63:0] eb, eo, em;
        logic [15:0] er;
        d    = (s == 0) ? D_A : D_B;
        p    = pre_of(s);
        n    = p + 32;
        c45e = (s == 0) && r.c45;
        rd   = c45e ? r.op[1] : (r.op == 2'b10);
        f32  = {c45e ? 2'b00 : 2'b01, r.op, r.phy, r.ra, 2'b10, r.data};
        er   = rd ? r.pv : last_rsp[s];
        eb = '0; eo = '0; em = '0;
        for (int k = 0; k < n; k++) begin
            pos = n - 1 - k;
            o   = !(rd && k >= p + 14);
            eo[pos] = o;
            if (o) begin
                em[pos] = 1'b1;
                eb[pos] = (k < p) ? 1'b1 : f32[31-(k-p)];
            end
        end

        if (!chained_in) begin
            @(negedge clk);
            drive_req(s, r, 1'b1);
        end
        phy_val[s] = r.pv;
        rc[s] = 0; cap_bits[s] = '0; cap_oe[s] = '0;
        #1;
        waited = 0;
        while (!rdy_v[s] && waited < 4 * d * n) begin
            @(negedge clk);
            #1;
            waited++;
        end
        if (!rdy_v[s]) begin
            check("accept_timeout", 64'(rdy_v[s]), 64'd1);
            drive_req(s, r, 1'b0);
            return;
        end
        if (chained_in) check("chain_accept_gap", 64'(waited), 64'd1);

        @(posedge clk);
        @(negedge clk);
        if (chain_out) drive_req(s, nxt, 1'b1);
        else           drive_req(s, r, 1'b0);
        check("busy_after_accept", 64'(busy_v[s]), 64'd1);
        check("ready_while_busy", 64'(rdy_v[s]), 64'd0);

        cyc   = 0;
        limit = 2 * d * n + 20;
        while (!rv_v[s] && cyc < limit) begin
            @(negedge clk);
            cyc++;
        end
        check("done_cycle", 64'(cyc), 64'(2 * d * n + 1));
        check("rsp_data", 64'(rsp_v[s]), 64'(er));
        check("busy_in_done", 64'(busy_v[s]), 64'd1);
        check("done_pads", {62'd0, mdc_v[s], oe_v[s]}, 64'd0);
        check("frame_bits", cap_bits[s] & em, eb);
        check("frame_oe", cap_oe[s], eo);
        check("bit_count", 64'(rc[s]), 64'(n));
        last_rsp[s] = er;

        if (!chain_out) begin
            @(negedge clk);
            check("rsp_pulse_width", 64'(rv_v[s]), 64'd0);
            check("idle_state", {59'd0, busy_v[s], rdy_v[s], mdc_v[s], oe_v[s], mo_v[s]}, 64'b01001);
        end
    endtask

    // Reset in the middle of a read must abort cleanly.
    task automatic reset_mid();
        req_t r;
        int   guard, seen;
        r = '{c45: 1'b0, op: 2'b10, phy: 5'h03, ra: 5'h02, data: 16'h0, pv: 16'h1357};
        phy_val[0] = r.pv;
        rc[0] = 0;
        @(negedge clk);
        drive_req(0, r, 1'b1);
        @(posedge clk);
        @(negedge clk);
        drive_req(0, r, 1'b0);
        guard = 0;
        while (rc[0] < 21 && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        check("reached_bit20", 64'(rc[0] >= 21), 64'd1);
        rst_a = 1'b1;
        @(negedge clk);
        check("abort_pads", {61'd0, mdc_a, oe_a, mo_a}, 64'b001);
        check("abort_busy_valid", {62'd0, bus_a.busy, bus_a.rsp_valid}, 64'd0);
        check("abort_rsp_data", 64'(bus_a.rsp_data), 64'd0);
        rst_a = 1'b0;
        #1;
        check("ready_after_release", 64'(bus_a.req_ready), 64'd1);
        last_rsp[0] = '0;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus_a.rsp_valid || mdc_a) seen++;
        end
        check("quiet_after_abort", 64'(seen), 64'd0);
    endtask

    initial begin
        req_t r, r2, dummy;
        dummy = '{c45: 1'b0, op: 2'b00, phy: 5'h0, ra: 5'h0, data: 16'h0, pv: 16'h0};
        for (int s = 0; s < 2; s++) begin
            rc[s] = 0; cap_bits[s] = '0; cap_oe[s] = '0;
            phy_val[s] = '0; last_rsp[s] = '0; prev_mdc[s] = 1'b0;
        end
        mi = 2'b11;
        rst_a = 1'b1; rst_b = 1'b1;
        drive_req(0, dummy, 1'b0);
        drive_req(1, dummy, 1'b0);
        repeat (3) @(negedge clk);
        check("reset_pads", {61'd0, mdc_a, oe_a, mo_a}, 64'b001);
        check("reset_regs", {45'd0, bus_a.rsp_valid, bus_a.busy, bus_a.rsp_data}, 64'd0);
        check("ready_in_reset", 64'(bus_a.req_ready), 64'd0);
        rst_a = 1'b0; rst_b = 1'b0;
        @(negedge clk);
        check("ready_after_reset", 64'(rdy_v), 64'b11);

        r = '{c45: 1'b0, op: 2'b01, phy: 5'h01, ra: 5'h00, data: 16'h8000, pv: 16'hFFFF};
        do_frame(0, r, 1'b0, 1'b0, dummy);
        r = '{c45: 1'b0, op: 2'b10, phy: 5'h03, ra: 5'h02, data: 16'h0000, pv: 16'hA5C3};
        do_frame(0, r, 1'b0, 1'b0, dummy);
        r = '{c45: 1'b1, op: 2'b00, phy: 5'h05, ra: 5'h01, data: 16'h1234, pv: 16'hBEEF};
        do_frame(0, r, 1'b0, 1'b0, dummy);
        r = '{c45: 1'b1, op: 2'b10, phy: 5'h05, ra: 5'h01, data: 16'h0000, pv: 16'h5A5A};
        do_frame(0, r, 1'b0, 1'b0, dummy);
        r = '{c45: 1'b0, op: 2'b01, phy: 5'h1F, ra: 5'h11, data: 16'hC0DE, pv: 16'h0F0F};
        do_frame(1, r, 1'b0, 1'b0, dummy);
        r = '{c45: 1'b1, op: 2'b11, phy: 5'h02, ra: 5'h07, data: 16'h00FF, pv: 16'h7777};
        do_frame(1, r, 1'b0, 1'b0, dummy);

        r  = '{c45: 1'b0, op: 2'b01, phy: 5'h0A, ra: 5'h15, data: 16'h4321, pv: 16'h1111};
        r2 = '{c45: 1'b1, op: 2'b11, phy: 5'h14, ra: 5'h0B, data: 16'h0000, pv: 16'h9ABC};
        do_frame(0, r, 1'b0, 1'b1, r2);
        do_frame(0, r2, 1'b1, 1'b0, dummy);

        reset_mid();

        for (int i = 0; i < 14; i++) begin
            int s;
            s = (i % 3 == 0) ? 0 : 1;
            r = rand_req();
            if (i % 5 == 4) begin
                r2 = rand_req();
                do_frame(s, r, 1'b0, 1'b1, r2);
                do_frame(s, r2, 1'b1, 1'b0, dummy);
            end else begin
                do_frame(s, r, 1'b0, 1'b0, dummy);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
